// File: rtl/cpu7_ifu_iq.sv
`default_nettype none
// ============================================================================
//  Module   : cpu7_ifu_iq
//  Purpose  : IFU instruction queue. Buffers fetched instructions together
//             with their PC and fetch-exception flag, and presents the
//             oldest entry to decode under a valid/ready handshake. A
//             pipeline flush discards every queued entry.
//  Ports    :
//    clk            core clock, rising edge
//    resetn         asynchronous active-low reset
//    fdp_iq_vld     fetch presents an instruction
//    fdp_iq_inst    fetched instruction word
//    fdp_iq_pc      PC of the fetched instruction
//    fdp_iq_excp    fetch exception flag for this PC
//    iq_fdp_rdy     queue can accept a push
//    iq_dec_vld     head entry valid for decode
//    iq_dec_inst    head instruction (NOP when the entry carries an exception)
//    iq_dec_pc      head PC
//    iq_dec_excp    head carries a fetch exception
//    dec_iq_rdy     decode consumes the head this cycle
//    exu_ifu_flush  flush all entries
//    iq_cnt         current occupancy
//  Revision : 1.0  initial release
// ============================================================================
module cpu7_ifu_iq #(
   parameter int DEPTH = 4,
   parameter int GRLEN = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     fdp_iq_vld,
   input  logic [31:0]              fdp_iq_inst,
   input  logic [GRLEN-1:0]         fdp_iq_pc,
   input  logic                     fdp_iq_excp,
   output logic                     iq_fdp_rdy,
   output logic                     iq_dec_vld,
   output logic [31:0]              iq_dec_inst,
   output logic [GRLEN-1:0]         iq_dec_pc,
   output logic                     iq_dec_excp,
   input  logic                     dec_iq_rdy,
   input  logic                     exu_ifu_flush,
   output logic [$clog2(DEPTH):0]   iq_cnt
);

   localparam int               C_AW   = $clog2(DEPTH);
   localparam int               C_CW   = C_AW + 1;
   localparam logic [C_CW-1:0]  C_FULL = C_CW'(DEPTH);
   // andi r0,r0,0 : harmless filler for entries that faulted in fetch
   localparam logic [31:0]      C_NOP  = 32'h0340_0000;

   // Data-only storage; never reset.
   logic [31:0]       r_inst [DEPTH];
   logic [GRLEN-1:0]  r_pc   [DEPTH];
   logic              r_excp [DEPTH];

   logic [C_AW-1:0]   r_wr_ptr;
   logic [C_AW-1:0]   r_rd_ptr;
   logic [C_CW-1:0]   r_count;

   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign w_empty     = (r_count == '0);
   // Ready looks only at registered occupancy: a same-cycle pop never frees
   // a slot for a push when full.
   assign iq_fdp_rdy  = (r_count != C_FULL);
   assign iq_dec_vld  = !w_empty && !exu_ifu_flush;
   assign w_push      = fdp_iq_vld && iq_fdp_rdy && !exu_ifu_flush;
   assign w_pop       = iq_dec_vld && dec_iq_rdy;

   assign iq_dec_inst = r_excp[r_rd_ptr] ? C_NOP : r_inst[r_rd_ptr];
   assign iq_dec_pc   = r_pc[r_rd_ptr];
   // Gated with occupancy so the unreset flag storage cannot leak out of reset.
   assign iq_dec_excp = r_excp[r_rd_ptr] && !w_empty;
   assign iq_cnt      = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_wr_ptr] <= fdp_iq_inst;
         r_pc[r_wr_ptr]   <= fdp_iq_pc;
         r_excp[r_wr_ptr] <= fdp_iq_excp;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (exu_ifu_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CW'(1);
            2'b01:   r_count <= r_count - C_CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (resetn) begin
         assert (r_count <= C_FULL);
         assert (!(w_pop && w_empty));
         assert (!(w_push && (r_count == C_FULL)));
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu7_ifu_iq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu7_ifu_iq
//  Purpose  : Self-checking bench for cpu7_ifu_iq. A reference queue model
//             tracks occupancy and contents; every falling edge compares the
//             DUT handshake, occupancy and head entry against it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu7_ifu_iq;

   localparam int DEPTH = 4;
   localparam int GRLEN = 32;
   localparam logic [31:0] C_NOP = 32'h0340_0000;

   logic              clk = 1'b0;
   logic              resetn;
   logic              fdp_iq_vld;
   logic [31:0]       fdp_iq_inst;
   logic [GRLEN-1:0]  fdp_iq_pc;
   logic              fdp_iq_excp;
   logic              iq_fdp_rdy;
   logic              iq_dec_vld;
   logic [31:0]       iq_dec_inst;
   logic [GRLEN-1:0]  iq_dec_pc;
   logic              iq_dec_excp;
   logic              dec_iq_rdy;
   logic              exu_ifu_flush;
   logic [$clog2(DEPTH):0] iq_cnt;

   cpu7_ifu_iq #(.DEPTH(DEPTH), .GRLEN(GRLEN)) u_dut (
      .clk           (clk),
      .resetn        (resetn),
      .fdp_iq_vld    (fdp_iq_vld),
      .fdp_iq_inst   (fdp_iq_inst),
      .fdp_iq_pc     (fdp_iq_pc),
      .fdp_iq_excp   (fdp_iq_excp),
      .iq_fdp_rdy    (iq_fdp_rdy),
      .iq_dec_vld    (iq_dec_vld),
      .iq_dec_inst   (iq_dec_inst),
      .iq_dec_pc     (iq_dec_pc),
      .iq_dec_excp   (iq_dec_excp),
      .dec_iq_rdy    (dec_iq_rdy),
      .exu_ifu_flush (exu_ifu_flush),
      .iq_cnt        (iq_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [GRLEN-1:0] pc;
      logic [31:0]      inst;
      logic             excp;
   } ent_t;

   ent_t q[$];
   int   m_cnt     = 0;
   bit   last_push = 1'b0;
   int   n_tests   = 0;
   int   n_fail    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model, evaluated mid-cycle while inputs are stable.
   always @(negedge clk) begin
      if (resetn) begin
         bit   m_vld, m_push, m_pop;
         ent_t e;
         m_vld = (m_cnt != 0) && !exu_ifu_flush;
         chk("vld", iq_dec_vld, m_vld);
         chk("rdy", iq_fdp_rdy, m_cnt != DEPTH);
         chk("cnt", iq_cnt, m_cnt);
         if (m_vld) begin
            chk("head_pc",   iq_dec_pc,   q[0].pc);
            chk("head_inst", iq_dec_inst, q[0].inst);
            chk("head_excp", iq_dec_excp, q[0].excp);
         end
         m_push = fdp_iq_vld && (m_cnt != DEPTH) && !exu_ifu_flush;
         m_pop  = m_vld && dec_iq_rdy;
         last_push = m_push;
         if (exu_ifu_flush) begin
            q.delete();
            m_cnt = 0;
         end else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
               e.pc   = fdp_iq_pc;
               e.excp = fdp_iq_excp;
               e.inst = fdp_iq_excp ? C_NOP : fdp_iq_inst;
               q.push_back(e);
            end
            m_cnt = m_cnt + int'(m_push) - int'(m_pop);
         end
      end
   end

   // Waits until the currently presented push is accepted; returns at posedge+1.
   task automatic wait_acc();
      int budget = 40;
      forever begin
         @(posedge clk);
         if (last_push) break;
         budget--;
         if (budget == 0) begin
            chk("push_timeout", 1, 0);
            break;
         end
      end
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic excp);
      fdp_iq_vld  = 1'b1;
      fdp_iq_inst = inst;
      fdp_iq_pc   = pc;
      fdp_iq_excp = excp;
      wait_acc();
   endtask

   task automatic idle(input int n);
      fdp_iq_vld = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      resetn        = 1'b0;
      fdp_iq_vld    = 1'b0;
      fdp_iq_inst   = '0;
      fdp_iq_pc     = '0;
      fdp_iq_excp   = 1'b0;
      dec_iq_rdy    = 1'b0;
      exu_ifu_flush = 1'b0;
      #1;
      chk("rst_vld",  iq_dec_vld,  0);
      chk("rst_rdy",  iq_fdp_rdy,  1);
      chk("rst_cnt",  iq_cnt,      0);
      chk("rst_excp", iq_dec_excp, 0);
      #21 resetn = 1'b1;
      @(posedge clk); #1;

      // Single push then pop
      push(32'h0280_0421, 32'h1c00_0000, 1'b0);
      idle(0);
      @(negedge clk);
      chk("single_inst", iq_dec_inst, 32'h0280_0421);
      chk("single_pc",   iq_dec_pc,   32'h1c00_0000);
      @(posedge clk); #1;
      dec_iq_rdy = 1'b1;
      @(posedge clk); #1;
      dec_iq_rdy = 1'b0;
      chk("single_drained", iq_cnt, 0);

      // Fill to full, hold a fifth push, then drain in order
      for (int i = 0; i < DEPTH; i++) push(32'h0000_1000 + i, 32'h1c00_0000 + 4 * i, 1'b0);
      fdp_iq_pc   = 32'h1c00_0010;
      fdp_iq_inst = 32'h0000_1004;
      repeat (3) @(posedge clk);
      #1;
      chk("full_cnt", iq_cnt, DEPTH);
      chk("full_rdy", iq_fdp_rdy, 0);
      dec_iq_rdy = 1'b1;
      wait_acc();
      idle(6);
      dec_iq_rdy = 1'b0;
      chk("full_drained", iq_cnt, 0);

      // Streaming push+pop every cycle, wrapping the pointers several times
      dec_iq_rdy = 1'b1;
      for (int i = 0; i < 20; i++) push(32'h0000_2000 + i, 32'h1c00_0200 + 4 * i, 1'b0);
      chk("stream_cnt", iq_cnt, 1);
      idle(2);
      dec_iq_rdy = 1'b0;

      // Exception entry gets NOP-substituted
      push(32'hffff_ffff, 32'h1c00_0300, 1'b1);
      idle(0);
      @(negedge clk);
      chk("excp_inst", iq_dec_inst, C_NOP);
      chk("excp_flag", iq_dec_excp, 1);
      chk("excp_pc",   iq_dec_pc,   32'h1c00_0300);
      @(posedge clk); #1;
      dec_iq_rdy = 1'b1;
      idle(1);
      dec_iq_rdy = 1'b0;

      // Flush with concurrent push and pop attempts
      for (int i = 0; i < 3; i++) push(32'h0000_3000 + i, 32'h1c00_0400 + 4 * i, 1'b0);
      fdp_iq_pc     = 32'h1c00_0480;
      fdp_iq_inst   = 32'h0000_3fff;
      dec_iq_rdy    = 1'b1;
      exu_ifu_flush = 1'b1;
      @(negedge clk);
      chk("flush_vld", iq_dec_vld, 0);
      @(posedge clk); #1;
      exu_ifu_flush = 1'b0;
      fdp_iq_vld    = 1'b0;
      dec_iq_rdy    = 1'b0;
      chk("flush_cnt", iq_cnt, 0);
      push(32'h0000_4000, 32'h1c00_0100, 1'b0);
      idle(0);
      @(negedge clk);
      chk("post_flush_pc", iq_dec_pc, 32'h1c00_0100);
      @(posedge clk); #1;
      dec_iq_rdy = 1'b1;
      idle(1);
      dec_iq_rdy = 1'b0;

      // Asynchronous reset mid-stream
      push(32'h0000_5000, 32'h1c00_0500, 1'b0);
      push(32'h0000_5001, 32'h1c00_0504, 1'b0);
      idle(0);
      #2 resetn = 1'b0;
      #1;
      chk("arst_vld",  iq_dec_vld,  0);
      chk("arst_cnt",  iq_cnt,      0);
      chk("arst_rdy",  iq_fdp_rdy,  1);
      chk("arst_excp", iq_dec_excp, 0);
      q.delete();
      m_cnt     = 0;
      last_push = 1'b0;
      @(negedge clk);
      #2 resetn = 1'b1;
      @(posedge clk); #1;
      push(32'h0000_6000, 32'h1c00_0600, 1'b0);
      push(32'h0000_6001, 32'h1c00_0604, 1'b0);
      idle(0);
      @(negedge clk);
      chk("post_rst_pc", iq_dec_pc, 32'h1c00_0600);
      @(posedge clk); #1;
      dec_iq_rdy = 1'b1;
      idle(3);
      dec_iq_rdy = 1'b0;
      chk("final_cnt", iq_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
